i_cache_ctrl: RTL and testbench
===============================

I_CACHE_CTRL -- requirements
Module: i_cache_ctrl

Interface
Parameters: none; geometry is fixed at 8 sets, 16-byte blocks, direct-mapped.
REQ-001 SHALL have port CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port READ_EN  input  1  CPU instruction-fetch request, held high until BUSYWAIT is low.
REQ-004 SHALL have port ADDR  input  32  CPU byte address of the instruction.
REQ-005 SHALL have port INSTR  output  32  fetched instruction word.
REQ-006 SHALL have port BUSYWAIT  output  1  CPU stall request.
REQ-007 SHALL have port MEM_READ  output  1  block-read request to instruction memory.
REQ-008 SHALL have port MEM_ADDR  output  28  block address to memory, equal to ADDR[31:4].
REQ-009 SHALL have port MEM_BUSYWAIT  input  1  memory stall; low marks the block as complete.
REQ-010 SHALL have port MEM_READDATA  input  128  memory block, byte 0 in bits [7:0].

Function
REQ-011 SHALL split ADDR as follows: tag = ADDR[31:7] (25 bits), index = ADDR[6:4], word offset = ADDR[3:2]; ADDR[1:0] ignored.
REQ-012 SHALL hold per set: 1 valid bit, 25-bit tag, 128-bit data block.
REQ-013 SHALL define hit = READ_EN & valid[index] & (tag[index] == ADDR tag), evaluated combinationally.
REQ-014 SHALL drive INSTR combinationally from the indexed block: offset 0 -> [31:0], 1 -> [63:32], 2 -> [95:64], 3 -> [127:96].
REQ-015 SHALL implement the FSM with states IDLE, FETCH and UPDATE.
REQ-016 In IDLE with a hit, SHALL keep BUSYWAIT low in the same cycle (zero-wait hit) and stay in IDLE.
REQ-017 In IDLE with READ_EN and a miss, SHALL raise BUSYWAIT combinationally and move to FETCH on the next edge.
REQ-018 In FETCH, SHALL hold MEM_READ=1 and MEM_ADDR=ADDR[31:4]; on the first edge where MEM_BUSYWAIT=0, SHALL move to UPDATE.
REQ-019 In UPDATE, SHALL hold MEM_READ=0, write MEM_READDATA into block[index], set tag[index] and valid[index]=1 on that edge, then return to IDLE.
REQ-020 On the IDLE cycle after UPDATE, the request SHALL hit and deassert BUSYWAIT.
REQ-021 SHALL hold BUSYWAIT = 1 whenever state != IDLE, and SHALL hold BUSYWAIT = READ_EN & ~hit in IDLE.
REQ-022 SHALL drive MEM_READ = 0 in IDLE and UPDATE.
REQ-023 SHALL hold MEM_ADDR at ADDR[31:4] in all states; the value is only meaningful while MEM_READ=1.
REQ-024 With READ_EN low, SHALL keep state IDLE, BUSYWAIT=0 and MEM_READ=0.
REQ-025 ADDR changing during FETCH or UPDATE is a CPU protocol violation; the block SHALL fill the set and tag of the ADDR present at the UPDATE edge.
REQ-026 A miss to a valid set SHALL overwrite it; no write-back SHALL occur, because the cache is read-only.

Reset
REQ-027 On RESET high, SHALL immediately (asynchronously) set state=IDLE, clear all 8 valid bits, and force MEM_READ=0.
REQ-028 While RESET is high, BUSYWAIT SHALL equal READ_EN, because every access misses.
REQ-029 Tags and data SHALL be left uninitialised by reset.
REQ-030 If reset occurs mid-FETCH or mid-UPDATE, SHALL abort the fill with no set left valid; a new miss after reset restarts the fill.

Verification
REQ-031 Cold miss: reset, then READ_EN=1, ADDR=0x0000_0004 -> BUSYWAIT=1 and MEM_READ=1 with MEM_ADDR=0x0000000 until the 16-cycle memory completes; then UPDATE; next cycle BUSYWAIT=0 and INSTR=bytes 7..4 of the block.
REQ-032 Hit in same block: ADDR=0x0000_000C after the fill -> BUSYWAIT=0 in the same cycle, MEM_READ stays 0, INSTR=block[127:96].
REQ-033 Conflict miss: ADDR=0x0000_0080 (same index 0, tag 1) -> refetch with MEM_ADDR=0x0000008; then ADDR=0x0000_0000 misses again.
REQ-034 Index coverage: sweep ADDR=0x00..0x7C -> exactly 8 fills, then a second sweep has all hits with zero MEM_READ cycles.
REQ-035 Reset mid-fill: assert RESET on the 5th FETCH cycle -> MEM_READ=0 immediately and state IDLE; the same ADDR then misses and completes a full fill.
REQ-036 Idle: READ_EN=0 with arbitrary ADDR -> BUSYWAIT=0 and MEM_READ=0 on every cycle.

Source files
------------

// File: rtl/i_cache_ctrl.sv
// i_cache_ctrl: direct-mapped read-only instruction cache, 8 sets x 16-byte blocks
// Ports: CLK rising-edge clock; RESET async active-high reset;
//   READ_EN/ADDR CPU fetch request; INSTR/BUSYWAIT fetched word and CPU stall;
//   MEM_READ/MEM_ADDR block-read request; MEM_BUSYWAIT/MEM_READDATA memory stall and block.
module i_cache_ctrl (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         READ_EN,
   input  logic [31:0]  ADDR,
   output logic [31:0]  INSTR,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic [27:0]  MEM_ADDR,
   input  logic         MEM_BUSYWAIT,
   input  logic [127:0] MEM_READDATA
);
   typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;
   state_t state, state_nx;
   logic [7:0] valid;
   logic [24:0] tags [8];
   logic [127:0] blocks [8];
   logic [24:0] tag;
   logic [2:0] index;
   logic [1:0] offset;
   logic hit, miss;
   logic unused_byte_sel;
   assign tag = ADDR[31:7];
   assign index = ADDR[6:4];
   assign offset = ADDR[3:2];
   assign unused_byte_sel = ^ADDR[1:0];
   assign hit = READ_EN & valid[index] & (tags[index] == tag);
   assign miss = READ_EN & ~hit;
   assign INSTR = blocks[index][{offset, 5'd0} +: 32];
   assign MEM_ADDR = ADDR[31:4];
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = IDLE;
      BUSYWAIT = 1'b1;
      MEM_READ = 1'b0;
      if (state == IDLE) begin
         BUSYWAIT = miss;
         state_nx = miss ? FETCH : IDLE;
      end else if (state == FETCH) begin
         MEM_READ = 1'b1;
         state_nx = MEM_BUSYWAIT ? FETCH : UPDATE;
      end
   end
   // Only the valid bits are reset; a stale tag/data pair is harmless while its set is invalid.
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) valid <= '0;
      else if (state == UPDATE) valid[index] <= 1'b1;
   always_ff @(posedge CLK)
      if (state == UPDATE) begin
         tags[index] <= tag;
         blocks[index] <= MEM_READDATA;
      end
endmodule

// File: tb/tb_i_cache_ctrl.sv
// tb_i_cache_ctrl: self-checking bench for i_cache_ctrl with a 16-cycle block memory model
module tb_i_cache_ctrl;
   logic         CLK = 1'b0;
   logic         RESET;
   logic         READ_EN;
   logic [31:0]  ADDR;
   logic [31:0]  INSTR;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [27:0]  MEM_ADDR;
   logic         MEM_BUSYWAIT;
   logic [127:0] MEM_READDATA;

   int total = 0;
   int passed = 0;
   int mr_total = 0;
   logic [4:0] mcnt;

   typedef struct {
      logic [31:0] addr;
      int          fills;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      int          fills;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[14];

   i_cache_ctrl dut (
      .CLK(CLK), .RESET(RESET), .READ_EN(READ_EN), .ADDR(ADDR), .INSTR(INSTR),
      .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDR(MEM_ADDR),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READDATA(MEM_READDATA)
   );

   always #5 CLK = ~CLK;

   // Memory: each word holds its own word-aligned byte address scrambled by a constant;
   // a block completes on the 16th cycle of a read request.
   always @(posedge CLK) mcnt <= MEM_READ ? mcnt + 5'd1 : 5'd0;
   always @(negedge CLK) if (MEM_READ) mr_total++;
   assign MEM_BUSYWAIT = !(MEM_READ && mcnt == 5'd15);
   always_comb begin
      MEM_READDATA = '0;
      for (int w = 0; w < 4; w++)
         MEM_READDATA[32*w +: 32] = {MEM_ADDR, 2'(w), 2'b00} ^ 32'hA5A5_5A5A;
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drives one fetch, waits (bounded) for BUSYWAIT low, then compares against the scoreboard.
   task automatic run_access(input logic [31:0] a, input int fills);
      exp_t e;
      int n, mr;
      logic addr_ok;
      e.instr = word_of(a);
      e.fills = fills;
      sb.push_back(e);
      READ_EN = 1'b1;
      ADDR = a;
      n = 0;
      mr = 0;
      addr_ok = 1'b1;
      @(negedge CLK);
      while (BUSYWAIT && n < 200) begin
         if (MEM_READ) begin
            mr++;
            if (MEM_ADDR !== a[31:4]) addr_ok = 1'b0;
         end
         @(negedge CLK);
         n++;
      end
      e = sb.pop_front();
      chk($sformatf("busy_cycles@%h", a), 32'(n), 32'(e.fills * 18));
      chk($sformatf("memread_cycles@%h", a), 32'(mr), 32'(e.fills * 16));
      chk($sformatf("mem_addr@%h", a), 32'(addr_ok), 32'd1);
      chk($sformatf("instr@%h", a), INSTR, e.instr);
      chk($sformatf("memread_after@%h", a), 32'(MEM_READ), 32'd0);
      @(posedge CLK);
      #1 READ_EN = 1'b0;
   endtask

   initial begin
      int k, m0;
      vecs = '{
         '{32'h0000_0004, 1}, '{32'h0000_000C, 0}, '{32'h0000_0000, 0}, '{32'h0000_0008, 0},
         '{32'h0000_0080, 1}, '{32'h0000_0084, 0}, '{32'h0000_0000, 1}, '{32'h0000_008C, 1},
         '{32'hDEAD_BEE4, 1}, '{32'hDEAD_BEEB, 0}, '{32'h0000_0064, 1}, '{32'hDEAD_BEE0, 1},
         '{32'h8000_0000, 1}, '{32'h0000_0080, 1}
      };
      RESET = 1'b1;
      READ_EN = 1'b1;
      ADDR = 32'h0000_0044;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_busywait_rd", 32'(BUSYWAIT), 32'd1);
      chk("reset_memread", 32'(MEM_READ), 32'd0);
      READ_EN = 1'b0;
      #1 chk("reset_busywait_idle", 32'(BUSYWAIT), 32'd0);
      @(posedge CLK);
      #1 RESET = 1'b0;

      for (int i = 0; i < 14; i++) run_access(vecs[i].addr, vecs[i].fills);

      for (int i = 0; i < 20; i++) begin
         ADDR = (i == 0) ? 32'h0000_0080 : $urandom;
         @(negedge CLK);
         chk("idle_busy_memread", {30'd0, BUSYWAIT, MEM_READ}, 32'd0);
         @(posedge CLK);
         #1;
      end

      RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      m0 = mr_total;
      for (int i = 0; i < 32; i++) run_access(32'(4 * i), (i % 4 == 0) ? 1 : 0);
      chk("sweep1_fills", 32'((mr_total - m0) / 16), 32'd8);
      m0 = mr_total;
      for (int i = 0; i < 32; i++) run_access(32'(4 * i), 0);
      chk("sweep2_memread", 32'(mr_total - m0), 32'd0);

      READ_EN = 1'b1;
      ADDR = 32'h0000_0140;
      k = 0;
      for (int n = 0; n < 100 && k < 5; n++) begin
         @(negedge CLK);
         if (MEM_READ) k++;
      end
      chk("midfill_reached", 32'(k), 32'd5);
      RESET = 1'b1;
      #1 chk("midfill_memread", 32'(MEM_READ), 32'd0);
      chk("midfill_busywait", 32'(BUSYWAIT), 32'd1);
      @(posedge CLK);
      #1 RESET = 1'b0;
      READ_EN = 1'b0;
      run_access(32'h0000_0140, 1);
      run_access(32'h0000_0004, 1);

      READ_EN = 1'b1;
      ADDR = 32'h0000_0250;
      k = 0;
      for (int n = 0; n < 100 && k < 2; n++) begin
         @(negedge CLK);
         if (k == 0 && MEM_READ) k = 1;
         else if (k == 1 && !MEM_READ) k = 2;
      end
      chk("update_reached", 32'(k), 32'd2);
      chk("update_busywait", 32'(BUSYWAIT), 32'd1);
      RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      READ_EN = 1'b0;
      run_access(32'h0000_0250, 1);
      run_access(32'h0000_0254, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
